axi_handshake_monitor: RTL and testbench

- Synthesizable, cycle-accurate observer of the four AXI4 data-path channels: AW, W, AR and R.
- Counts transfers and stall cycles per channel.
- Tracks outstanding burst lengths, checks each burst's last-beat position, and detects valid/payload instability during stalls.
- Sits beside the bench's AXI master/slave as the hardware source of statistics and sticky error flags that the logging layer reads and reports.

---
 rtl/axi_mon_pkg.sv | 40 ++++
 rtl/axi_mon_len_fifo.sv | 75 +++++++
 rtl/axi_handshake_monitor.sv | 266 ++++++++++++++++++++++++++
 tb/tb_axi_handshake_monitor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_mon_pkg
// Description : Shared types for the AXI handshake monitor. Holds the counter
//               select encoding, the error-bit index map and the saturating
//               increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_mon_pkg;

    // Counter select encoding for stat_sel.
    typedef enum logic [2:0] {
        STAT_AW_XFER  = 3'd0,
        STAT_W_XFER   = 3'd1,
        STAT_AR_XFER  = 3'd2,
        STAT_R_XFER   = 3'd3,
        STAT_AW_STALL = 3'd4,
        STAT_W_STALL  = 3'd5,
        STAT_AR_STALL = 3'd6,
        STAT_R_STALL  = 3'd7
    } stat_sel_e;

    // Bit positions inside err_flags.
    localparam int ERR_AW_STAB  = 0;
    localparam int ERR_W_STAB   = 1;
    localparam int ERR_AR_STAB  = 2;
    localparam int ERR_R_STAB   = 3;
    localparam int ERR_WR_LAST  = 4;
    localparam int ERR_RD_LAST  = 5;
    localparam int ERR_NO_OUTST = 6;
    localparam int ERR_OVERFLOW = 7;

    // Increment that sticks at max_val; callers zero-extend to 64 bits.
    function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                            input logic [63:0] max_val);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mon_len_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axi_mon_len_fifo
// Description : Small synchronous FIFO of burst lengths. Supports push and pop
//               in the same cycle; when empty and pushing, the incoming value
//               is presented on head so it can be consumed in that cycle.
//               A push while full and not popping is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mon_len_fifo
    import axi_mon_pkg::*;
#(
    parameter int LEN_WIDTH = 8,
    parameter int DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [LEN_WIDTH-1:0]     push_data,
    output logic [LEN_WIDTH-1:0]     head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                 c_ptr_w     = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_cnt_one   = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w:0]   c_depth_cnt = (c_ptr_w + 1)'(DEPTH);

    logic [LEN_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 w_bypass;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_depth_cnt);
    assign count = r_count;

    // Empty + push + pop: the pushed length is consumed immediately, storage untouched.
    assign w_bypass  = empty & push & pop;
    assign head      = empty ? push_data : r_mem[r_rd_ptr];
    assign w_do_push = push & ~w_bypass & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    // Storage array; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_handshake_monitor.sv
`default_nettype none
// ============================================================================
// Module      : axi_handshake_monitor
// Description : Cycle-accurate observer of AXI4 AW/W/AR/R channels. Counts
//               transfers and stalls, tracks outstanding burst lengths, checks
//               last-beat placement and flags valid/payload instability.
//               Optional macro AXI_MON_ASSERT_EN enables simulation messages on
//               every newly raised error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_handshake_monitor
    import axi_mon_pkg::*;
#(
    parameter int ADDR_WIDTH        = 32,
    parameter int LEN_WIDTH         = 8,
    parameter int CNT_WIDTH         = 32,
    parameter int OUTSTANDING_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear,
    input  logic                                 aw_valid,
    input  logic                                 aw_ready,
    input  logic [ADDR_WIDTH-1:0]                aw_addr,
    input  logic [LEN_WIDTH-1:0]                 aw_len,
    input  logic                                 w_valid,
    input  logic                                 w_ready,
    input  logic                                 w_last,
    input  logic                                 ar_valid,
    input  logic                                 ar_ready,
    input  logic [ADDR_WIDTH-1:0]                ar_addr,
    input  logic [LEN_WIDTH-1:0]                 ar_len,
    input  logic                                 r_valid,
    input  logic                                 r_ready,
    input  logic                                 r_last,
    input  logic [2:0]                           stat_sel,
    output logic [CNT_WIDTH-1:0]                 stat_data,
    output logic [7:0]                           err_flags,
    output logic [$clog2(OUTSTANDING_DEPTH):0]   wr_outstanding,
    output logic [$clog2(OUTSTANDING_DEPTH):0]   rd_outstanding
);

    localparam int                   c_occ_w    = $clog2(OUTSTANDING_DEPTH) + 1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = {CNT_WIDTH{1'b1}};
    localparam logic [LEN_WIDTH:0]   c_beat_one = (LEN_WIDTH + 1)'(1);

    // Handshake decode.
    logic w_aw_xfer, w_aw_stall, w_w_xfer, w_w_stall;
    logic w_ar_xfer, w_ar_stall, w_r_xfer, w_r_stall;
    assign w_aw_xfer  = aw_valid &  aw_ready;
    assign w_aw_stall = aw_valid & ~aw_ready;
    assign w_w_xfer   = w_valid  &  w_ready;
    assign w_w_stall  = w_valid  & ~w_ready;
    assign w_ar_xfer  = ar_valid &  ar_ready;
    assign w_ar_stall = ar_valid & ~ar_ready;
    assign w_r_xfer   = r_valid  &  r_ready;
    assign w_r_stall  = r_valid  & ~r_ready;

    // Per-direction views: index 0 = write (AW/W), 1 = read (AR/R).
    logic [1:0]           w_req_xfer;
    logic [1:0]           w_beat_xfer;
    logic [1:0]           w_beat_last;
    logic [LEN_WIDTH-1:0] w_req_len [2];
    logic [c_occ_w-1:0]   w_occ     [2];
    logic [1:0]           w_last_err;
    logic [1:0]           w_orphan;
    logic [1:0]           w_ovf;

    assign w_req_xfer  = {w_ar_xfer, w_aw_xfer};
    assign w_beat_xfer = {w_r_xfer, w_w_xfer};
    assign w_beat_last = {r_last, w_last};
    assign w_req_len[0] = aw_len;
    assign w_req_len[1] = ar_len;

    // Burst tracking per direction: length FIFO plus beat counter.
    for (genvar d = 0; d < 2; d++) begin : g_dir
        logic [LEN_WIDTH-1:0] w_head;
        logic                 w_full;
        logic                 w_empty;
        logic                 w_head_ok;
        logic                 w_beat;
        logic                 w_len_hit;
        logic                 w_end;
        logic                 w_pop;
        logic [LEN_WIDTH:0]   r_beats;
        logic [LEN_WIDTH:0]   w_beats_next;

        // A beat is meaningful only if a length is stored or arriving this cycle.
        assign w_head_ok    = ~w_empty | w_req_xfer[d];
        assign w_beat       = w_beat_xfer[d] & w_head_ok;
        assign w_beats_next = r_beats + c_beat_one;
        assign w_len_hit    = (w_beats_next == ({1'b0, w_head} + c_beat_one));
        assign w_end        = w_beat_last[d] | w_len_hit;
        assign w_pop        = w_beat & w_end;

        assign w_last_err[d] = w_pop & (w_beat_last[d] ^ w_len_hit);
        assign w_orphan[d]   = w_beat_xfer[d] & ~w_head_ok;
        assign w_ovf[d]      = w_req_xfer[d] & w_full & ~w_pop;

        axi_mon_len_fifo #(
            .LEN_WIDTH (LEN_WIDTH),
            .DEPTH     (OUTSTANDING_DEPTH)
        ) u_len_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (w_req_xfer[d]),
            .pop       (w_pop),
            .push_data (w_req_len[d]),
            .head      (w_head),
            .count     (w_occ[d]),
            .full      (w_full),
            .empty     (w_empty)
        );

        // Beats seen so far in the current burst; restarts at each burst end.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_beats <= '0;
            end else if (w_pop) begin
                r_beats <= '0;
            end else if (w_beat) begin
                r_beats <= w_beats_next;
            end
        end
    end

    assign wr_outstanding = w_occ[0];
    assign rd_outstanding = w_occ[1];

    // Stall snapshot: who was stalled last cycle and with what payload.
    logic                  r_aw_stalled, r_w_stalled, r_ar_stalled, r_r_stalled;
    logic [ADDR_WIDTH-1:0] r_aw_addr, r_ar_addr;
    logic [LEN_WIDTH-1:0]  r_aw_len, r_ar_len;

    // Capture stall state and payload every cycle for next-cycle stability checks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aw_stalled <= 1'b0;
            r_w_stalled  <= 1'b0;
            r_ar_stalled <= 1'b0;
            r_r_stalled  <= 1'b0;
            r_aw_addr    <= '0;
            r_ar_addr    <= '0;
            r_aw_len     <= '0;
            r_ar_len     <= '0;
        end else begin
            r_aw_stalled <= w_aw_stall;
            r_w_stalled  <= w_w_stall;
            r_ar_stalled <= w_ar_stall;
            r_r_stalled  <= w_r_stall;
            r_aw_addr    <= aw_addr;
            r_ar_addr    <= ar_addr;
            r_aw_len     <= aw_len;
            r_ar_len     <= ar_len;
        end
    end

    // New error conditions observed this cycle.
    logic [7:0] w_err_set;
    always_comb begin
        w_err_set               = '0;
        w_err_set[ERR_AW_STAB]  = r_aw_stalled &
                                  (~aw_valid | (aw_addr != r_aw_addr) | (aw_len != r_aw_len));
        w_err_set[ERR_W_STAB]   = r_w_stalled & ~w_valid;
        w_err_set[ERR_AR_STAB]  = r_ar_stalled &
                                  (~ar_valid | (ar_addr != r_ar_addr) | (ar_len != r_ar_len));
        w_err_set[ERR_R_STAB]   = r_r_stalled & ~r_valid;
        w_err_set[ERR_WR_LAST]  = w_last_err[0];
        w_err_set[ERR_RD_LAST]  = w_last_err[1];
        w_err_set[ERR_NO_OUTST] = |w_orphan;
        w_err_set[ERR_OVERFLOW] = |w_ovf;
    end

    // Sticky error flags; clear beats any same-cycle set.
    logic [7:0] r_err_flags;
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_err_flags <= '0;
        end else begin
            r_err_flags <= r_err_flags | w_err_set;
        end
    end
    assign err_flags = r_err_flags;

    // Event vector in stat_sel order.
    logic [7:0] w_evt;
    always_comb begin
        w_evt                = '0;
        w_evt[STAT_AW_XFER]  = w_aw_xfer;
        w_evt[STAT_W_XFER]   = w_w_xfer;
        w_evt[STAT_AR_XFER]  = w_ar_xfer;
        w_evt[STAT_R_XFER]   = w_r_xfer;
        w_evt[STAT_AW_STALL] = w_aw_stall;
        w_evt[STAT_W_STALL]  = w_w_stall;
        w_evt[STAT_AR_STALL] = w_ar_stall;
        w_evt[STAT_R_STALL]  = w_r_stall;
    end

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] val);
        logic [63:0] v_wide;
        v_wide = sat_inc(64'(val), 64'(c_cnt_max));
        return v_wide[CNT_WIDTH-1:0];
    endfunction

    logic [CNT_WIDTH-1:0] r_cnt      [8];
    logic [CNT_WIDTH-1:0] w_cnt_next [8];

    // Next counter values: clear wins, otherwise saturating increment on event.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (clear) begin
                w_cnt_next[i] = '0;
            end else if (w_evt[i]) begin
                w_cnt_next[i] = cnt_inc(r_cnt[i]);
            end
        end
    end

    // Counter bank and registered readout of the post-update value.
    logic [CNT_WIDTH-1:0] r_stat_data;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
            r_stat_data <= '0;
        end else begin
            for (int i = 0; i < 8; i++) r_cnt[i] <= w_cnt_next[i];
            r_stat_data <= w_cnt_next[stat_sel];
        end
    end
    assign stat_data = r_stat_data;

`ifdef AXI_MON_ASSERT_EN
    logic [63:0] r_cycle;

    function automatic string err_name(input int idx);
        case (idx)
            ERR_AW_STAB:  return "AW_STAB";
            ERR_W_STAB:   return "W_STAB";
            ERR_AR_STAB:  return "AR_STAB";
            ERR_R_STAB:   return "R_STAB";
            ERR_WR_LAST:  return "WR_LAST";
            ERR_RD_LAST:  return "RD_LAST";
            ERR_NO_OUTST: return "NO_OUTST";
            default:      return "OVERFLOW";
        endcase
    endfunction

    // Report each flag the first time it rises.
    always_ff @(posedge clk) begin
        if (!rst_n) r_cycle <= '0;
        else        r_cycle <= r_cycle + 64'd1;
        for (int i = 0; i < 8; i++) begin
            if (rst_n && !clear && w_err_set[i] && !r_err_flags[i]) begin
                $error("axi_handshake_monitor: %s at cycle %0d (wr head=%0d beats=%0d, rd head=%0d beats=%0d)",
                       err_name(i), r_cycle, g_dir[0].w_head, g_dir[0].r_beats,
                       g_dir[1].w_head, g_dir[1].r_beats);
            end
        end
    end
`else
    // Silent build: flags and counters are the only report.
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_handshake_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_handshake_monitor
// Description : Self-checking bench for axi_handshake_monitor. A queue-based
//               reference model follows the observable rules; every cycle the
//               DUT outputs are compared against it. Directed scenarios pin
//               known literal results, then a randomized phase follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_handshake_monitor;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n, clear;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len;
    logic [2:0]  stat_sel;
    logic [31:0] stat_data;
    logic [7:0]  err_flags;
    logic [3:0]  wr_outstanding, rd_outstanding;

    axi_handshake_monitor #(
        .ADDR_WIDTH(32), .LEN_WIDTH(8), .CNT_WIDTH(32), .OUTSTANDING_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
        .stat_sel(stat_sel), .stat_data(stat_data), .err_flags(err_flags),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    longint unsigned m_cnt [8];
    logic [7:0]      m_err;
    logic [31:0]     m_stat;
    int              q [2][$];
    int              beats [2];
    bit              p_aw_st, p_w_st, p_ar_st, p_r_st;
    logic [31:0]     p_aw_addr, p_ar_addr;
    logic [7:0]      p_aw_len, p_ar_len;
    int              cyc = 0;

    function automatic void dir_step(input int d, input bit req, input int len,
                                     input bit beat, input bit last, inout logic [7:0] set);
        bit popping = 0;
        int head;
        bit hit;
        if (beat) begin
            if (q[d].size() == 0 && !req) begin
                set[6] = 1'b1;
            end else begin
                head = (q[d].size() > 0) ? q[d][0] : len;
                beats[d] = beats[d] + 1;
                hit = (beats[d] == head + 1);
                if (last || hit) begin
                    if (last != hit) set[4+d] = 1'b1;
                    popping = 1;
                    beats[d] = 0;
                end
            end
        end
        if (req) begin
            if (q[d].size() == DEPTH && !popping) set[7] = 1'b1;
            else q[d].push_back(len);
        end
        if (popping) void'(q[d].pop_front());
    endfunction

    function automatic void model_step();
        logic [7:0] ev;
        logic [7:0] set;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            m_err = 0; m_stat = 0;
            q[0].delete(); q[1].delete();
            beats[0] = 0; beats[1] = 0;
            p_aw_st = 0; p_w_st = 0; p_ar_st = 0; p_r_st = 0;
            p_aw_addr = 0; p_ar_addr = 0; p_aw_len = 0; p_ar_len = 0;
            return;
        end
        ev = {r_valid & ~r_ready, ar_valid & ~ar_ready, w_valid & ~w_ready, aw_valid & ~aw_ready,
              r_valid & r_ready, ar_valid & ar_ready, w_valid & w_ready, aw_valid & aw_ready};
        set = 0;
        if (p_aw_st && (!aw_valid || aw_addr != p_aw_addr || aw_len != p_aw_len)) set[0] = 1;
        if (p_w_st && !w_valid) set[1] = 1;
        if (p_ar_st && (!ar_valid || ar_addr != p_ar_addr || ar_len != p_ar_len)) set[2] = 1;
        if (p_r_st && !r_valid) set[3] = 1;
        dir_step(0, ev[0], int'(aw_len), ev[1], w_last, set);
        dir_step(1, ev[2], int'(ar_len), ev[3], r_last, set);
        if (clear) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            m_err = 0;
        end else begin
            for (int i = 0; i < 8; i++)
                if (ev[i] && m_cnt[i] < 64'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
            m_err = m_err | set;
        end
        m_stat = 32'(m_cnt[stat_sel]);
        p_aw_st = ev[4]; p_w_st = ev[5]; p_ar_st = ev[6]; p_r_st = ev[7];
        p_aw_addr = aw_addr; p_ar_addr = ar_addr; p_aw_len = aw_len; p_ar_len = ar_len;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("stat_data", 64'(stat_data), 64'(m_stat));
        chk("err_flags", 64'(err_flags), 64'(m_err));
        chk("wr_outstanding", 64'(wr_outstanding), 64'(q[0].size()));
        chk("rd_outstanding", 64'(rd_outstanding), 64'(q[1].size()));
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            cyc++;
            compare_all();
        end
    endtask

    task automatic idle();
        aw_valid = 0; aw_ready = 0; w_valid = 0; w_ready = 0; w_last = 0;
        ar_valid = 0; ar_ready = 0; r_valid = 0; r_ready = 0; r_last = 0;
        clear = 0;
    endtask

    task automatic read_stat(input int sel, input int exp, input string name);
        stat_sel = 3'(sel);
        tick();
        chk(name, 64'(stat_data), 64'(exp));
    endtask

    task automatic w_beat(input bit last);
        w_valid = 1; w_ready = 1; w_last = last; tick(); idle();
    endtask

    // Expected last flag for the next beat, occasionally wrong on purpose.
    function automatic bit want_last(input int d, input bit req, input int len);
        int head;
        if (q[d].size() > 0) head = q[d][0];
        else if (req) head = len;
        else return bit'($urandom_range(0, 1));
        return ((beats[d] + 1) == (head + 1)) ^ ($urandom_range(0, 19) == 0);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int k;
        idle();
        rst_n = 0; stat_sel = 0;
        aw_addr = 0; aw_len = 0; ar_addr = 0; ar_len = 0;
        tick(2);
        rst_n = 1;

        // reset state
        for (int s = 0; s < 8; s++) read_stat(s, 0, "reset_stat");
        chk("reset_err", 64'(err_flags), 64'h00);
        chk("reset_wr_outst", 64'(wr_outstanding), 64'd0);
        chk("reset_rd_outst", 64'(rd_outstanding), 64'd0);

        // AW len=3, four W beats with last on the fourth
        aw_valid = 1; aw_ready = 1; aw_addr = 32'h1000; aw_len = 8'd3; tick(); idle();
        chk("wr_outst_one", 64'(wr_outstanding), 64'd1);
        for (int b = 0; b < 4; b++) w_beat(b == 3);
        read_stat(0, 1, "aw_xfer_cnt");
        read_stat(1, 4, "w_xfer_cnt");
        chk("wr_outst_drained", 64'(wr_outstanding), 64'd0);
        chk("burst_ok_err", 64'(err_flags), 64'h00);

        // AW stalled 3 cycles then accepted; then an address change mid-stall
        aw_valid = 1; aw_ready = 0; aw_addr = 32'h100; aw_len = 0; tick(3);
        aw_ready = 1; tick(); idle();
        read_stat(4, 3, "aw_stall_cnt");
        chk("stable_stall_err", 64'(err_flags), 64'h00);
        aw_valid = 1; aw_ready = 0; aw_addr = 32'h100; tick(2);
        aw_addr = 32'h104; tick();
        aw_ready = 1; tick(); idle();
        chk("aw_unstable_err", 64'(err_flags), 64'h01);
        w_beat(1); w_beat(1);
        chk("wr_outst_after_stalls", 64'(wr_outstanding), 64'd0);
        clear = 1; tick(); idle();
        chk("clear_err", 64'(err_flags), 64'h00);

        // AR len=1 closed early by r_last, then a correct single-beat read
        ar_valid = 1; ar_ready = 1; ar_addr = 32'h2000; ar_len = 8'd1; tick(); idle();
        r_valid = 1; r_ready = 1; r_last = 1; tick(); idle();
        chk("rd_early_last_err", 64'(err_flags), 64'h20);
        chk("rd_outst_early", 64'(rd_outstanding), 64'd0);
        ar_valid = 1; ar_ready = 1; ar_len = 8'd0; tick(); idle();
        r_valid = 1; r_ready = 1; r_last = 1; tick(); idle();
        chk("rd_single_ok_err", 64'(err_flags), 64'h20);
        clear = 1; tick(); idle();

        // Nine AWs into an 8-deep FIFO, then an R beat with nothing outstanding
        for (int i = 0; i < 9; i++) begin
            aw_valid = 1; aw_ready = 1; aw_len = 0; aw_addr = 32'(i * 16); tick();
        end
        idle();
        chk("wr_outst_full", 64'(wr_outstanding), 64'd8);
        chk("overflow_err", 64'(err_flags), 64'h80);
        r_valid = 1; r_ready = 1; r_last = 1; tick(); idle();
        chk("orphan_err", 64'(err_flags), 64'hC0);
        for (int i = 0; i < 8; i++) w_beat(1);
        chk("wr_outst_refilled_drain", 64'(wr_outstanding), 64'd0);
        clear = 1; tick(); idle();

        // Bypass: AW and its only W beat in the same cycle with an empty FIFO
        aw_valid = 1; aw_ready = 1; aw_len = 0; w_valid = 1; w_ready = 1; w_last = 1;
        tick(); idle();
        chk("bypass_outst", 64'(wr_outstanding), 64'd0);
        chk("bypass_err", 64'(err_flags), 64'h00);

        // clear coinciding with a W transfer
        clear = 1; tick(); idle();
        aw_valid = 1; aw_ready = 1; aw_len = 8'd1; tick(); idle();
        stat_sel = 3'd1;
        clear = 1; w_valid = 1; w_ready = 1; w_last = 0; tick();
        chk("w_xfer_on_clear", 64'(stat_data), 64'd0);
        clear = 0; w_last = 1; tick(); idle();
        chk("w_xfer_after_clear", 64'(stat_data), 64'd1);
        chk("clear_w_err", 64'(err_flags), 64'h00);

        // Randomized traffic with occasional clear and reset
        for (int c = 0; c < 4000; c++) begin
            rst_n    = ($urandom_range(0, 499) != 0);
            clear    = ($urandom_range(0, 99) == 0);
            stat_sel = 3'($urandom_range(0, 7));
            if (aw_valid && !aw_ready) begin
                k = $urandom_range(0, 29);
                if (k == 0) aw_valid = 0;
                else if (k == 1) aw_addr = aw_addr ^ 32'h4;
                else if (k == 2) aw_len = aw_len ^ 8'h1;
            end else begin
                aw_valid = ($urandom_range(0, 3) == 0);
                aw_addr = $urandom; aw_len = 8'($urandom_range(0, 3));
            end
            aw_ready = ($urandom_range(0, 2) != 0);
            if (ar_valid && !ar_ready) begin
                k = $urandom_range(0, 29);
                if (k == 0) ar_valid = 0;
                else if (k == 1) ar_addr = ar_addr ^ 32'h8;
                else if (k == 2) ar_len = ar_len ^ 8'h2;
            end else begin
                ar_valid = ($urandom_range(0, 3) == 0);
                ar_addr = $urandom; ar_len = 8'($urandom_range(0, 3));
            end
            ar_ready = ($urandom_range(0, 2) != 0);
            if (w_valid && !w_ready) w_valid = ($urandom_range(0, 29) != 0);
            else w_valid = ($urandom_range(0, 9) < 7);
            w_ready = ($urandom_range(0, 4) != 0);
            w_last  = want_last(0, aw_valid & aw_ready, int'(aw_len));
            if (r_valid && !r_ready) r_valid = ($urandom_range(0, 29) != 0);
            else r_valid = ($urandom_range(0, 9) < 7);
            r_ready = ($urandom_range(0, 4) != 0);
            r_last  = want_last(1, ar_valid & ar_ready, int'(ar_len));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
